// File: rtl/nukv_fifogen_pkt.sv
// Single-clock first-word-fall-through AXI-stream FIFO with optional store-and-forward
// packet mode, exact beat/packet occupancy and a registered almost-full flag.
module nukv_fifogen_pkt #(
  parameter int ADDR_BITS   = 5,
  parameter int DATA_SIZE   = 16,
  parameter bit PACKET_MODE = 1'b0,
  parameter int AFULL_GAP   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 s_axis_talmostfull,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ADDR_BITS:0]   count,
  output logic [ADDR_BITS:0]   pkt_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_COUNT  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AFULL_LEVEL = (ADDR_BITS+1)'(DEPTH - AFULL_GAP);
  localparam logic [ADDR_BITS:0]   COUNT_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE     = ADDR_BITS'(1);

  logic [DATA_SIZE:0]   mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [DATA_SIZE:0]   head;
  logic [ADDR_BITS:0]   count_next;
  logic [ADDR_BITS:0]   pkt_count_next;
  logic                 cut_through;
  logic                 oversize;
  logic                 not_empty;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 wr_last;
  logic                 rd_last;

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

  // A full FIFO holding no complete packet can never release one, so it must drain
  // in stream fashion; the combinational term makes that visible on the filling edge.
  assign oversize = (count == FULL_COUNT) && (pkt_count == '0);

  assign m_axis_tvalid = not_empty &&
                         (!PACKET_MODE || (pkt_count != '0) || cut_through || oversize);
  assign m_axis_tdata  = not_empty ? head[DATA_SIZE-1:0] : '0;
  assign m_axis_tlast  = not_empty ? head[DATA_SIZE] : 1'b0;

  assign wr_fire = s_axis_tvalid && s_axis_tready;
  assign rd_fire = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr_fire && s_axis_tlast;
  assign rd_last = rd_fire && head[DATA_SIZE];

  always_comb begin
    count_next     = count;
    pkt_count_next = pkt_count;
    if (wr_fire && !rd_fire) begin
      count_next = count + COUNT_ONE;
    end else if (rd_fire && !wr_fire) begin
      count_next = count - COUNT_ONE;
    end
    if (wr_last && !rd_last) begin
      pkt_count_next = pkt_count + COUNT_ONE;
    end else if (rd_last && !wr_last) begin
      pkt_count_next = pkt_count - COUNT_ONE;
    end
  end

  // tready and almost-full look at next occupancy so they settle on the causing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      pkt_count          <= '0;
      cut_through        <= 1'b0;
      s_axis_tready      <= 1'b0;
      s_axis_talmostfull <= 1'b0;
    end else begin
      count              <= count_next;
      pkt_count          <= pkt_count_next;
      s_axis_tready      <= (count_next != FULL_COUNT);
      s_axis_talmostfull <= (count_next >= AFULL_LEVEL);
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (rd_last) begin
        cut_through <= 1'b0;
      end else if (PACKET_MODE && oversize) begin
        cut_through <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

endmodule

// File: doc/nukv_fifogen_pkt.md
# nukv_fifogen_pkt

Single-clock, first-word-fall-through AXI-stream FIFO with optional store-and-forward packet mode, occupancy counters and a configurable almost-full gap. It is the synchronous successor to the vendor-primitive stream FIFOs and is implemented in plain RTL (register/RAM array plus pointers). It is used between key-value pipeline stages that must only release whole packets, or that need exact occupancy for back-pressure decisions.

## Interface
- ADDR_BITS, 5: log2 of depth; DEPTH = 2**ADDR_BITS entries.
- DATA_SIZE, 16: tdata width in bits.
- PACKET_MODE, 0: 0 = stream (cut-through), 1 = store-and-forward on tlast.
- AFULL_GAP, 8: s_axis_talmostfull asserts when count >= DEPTH - AFULL_GAP; legal range 1..DEPTH-1.

- clk  in  1  single clock for both sides.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_SIZE  write data.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  write request.
- s_axis_tready  out  1  FIFO can accept a beat.
- s_axis_talmostfull  out  1  occupancy at/above threshold.
- m_axis_tdata  out  DATA_SIZE  head-of-FIFO data.
- m_axis_tlast  out  1  head-of-FIFO last flag.
- m_axis_tvalid  out  1  head beat readable.
- m_axis_tready  in  1  consumer accepts head beat.
- count  out  ADDR_BITS+1  beats stored, 0..DEPTH.
- pkt_count  out  ADDR_BITS+1  complete packets (tlast beats) stored.

## Operation
- Write fires on s_axis_tvalid && s_axis_tready; beats offered while tready=0 are not stored (no overflow corruption, unlike raw wr_en wiring).
- Read fires on m_axis_tvalid && m_axis_tready; head advances.
- Storage holds {tlast, tdata} per entry; pointers are ADDR_BITS wide and wrap modulo DEPTH; count disambiguates full/empty.
- count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count: +1 on write of a tlast=1 beat, -1 on read of a tlast=1 beat, unchanged if both in same cycle.
- s_axis_tready = registered (count_next != DEPTH); a read in the full cycle does not enable a same-cycle write (no bypass).
- Stream mode: m_axis_tvalid = (count != 0).
- Packet mode: m_axis_tvalid = (count != 0) && (pkt_count != 0 || cut_through).
- cut_through flag (packet mode only): set when count == DEPTH and pkt_count == 0 (oversize packet, would deadlock); cleared on the read of a tlast=1 beat. While set, beats drain in stream fashion.
- m_axis_tdata/m_axis_tlast are valid only while m_axis_tvalid=1; hold stable while tvalid && !tready.
- s_axis_talmostfull = (count >= DEPTH - AFULL_GAP), registered.

## Timing
- Reset (async assert, sync release): count=0, pkt_count=0, pointers=0, cut_through=0, m_axis_tvalid=0, s_axis_talmostfull=0, s_axis_tready=0; tready rises on the first clk edge after rst falls. m_axis_tdata/tlast reset to 0.
- Reset mid-operation discards all contents; no partial packet survives.
- Write-to-read latency, stream mode: beat written at edge N is presented with m_axis_tvalid=1 after edge N (1 cycle).
- Packet mode: first beat of a packet becomes valid 1 cycle after the tlast beat is written.
- Full throughput: one write and one read per cycle sustained when 0 < count < DEPTH.
- Empty: simultaneous write with count=0 is stored; no read that cycle (tvalid was 0).
- Full: tready=0 from the edge where count reaches DEPTH; returns to 1 the cycle after the first read.
- count, pkt_count, talmostfull update on the same edge as the causing handshake.

## Test plan
- Stream mode, ADDR_BITS=3: write 8 beats 0x01..0x08 with m_axis_tready=0 -> tready=0 after 8th, count=8, talmostfull=1 from count=0 (gap 8 -> threshold 0; use AFULL_GAP=2: asserts at count=6); then read -> data 0x01..0x08 in order, count returns 0.
- Simultaneous read/write at count=4 for 20 cycles with incrementing data -> count stays 4, output order exact, pointer wrap across entry 7->0 transparent.
- Packet mode: write 3-beat packet (tlast on beat 3) with tready held 1 -> m_axis_tvalid stays 0 until 1 cycle after beat 3 written, pkt_count=1, then 3 beats out back-to-back with tlast on third, pkt_count=0.
- Packet mode, DEPTH=8: write 12-beat packet -> at count=8 cut_through sets, tvalid=1, all 12 beats drain in order, cut_through clears on tlast read, next short packet is store-and-forward again.
- Offer beats while full -> none stored, count stays 8, output sequence has no gaps or duplicates.
- Assert rst with count=5, pkt_count=2 -> all outputs at reset values immediately; tready=1 one edge after release; subsequent traffic starts at fresh data.
